// File: rtl/ps_pkg.sv
// ps_pkg: shared state encoding and lane symbols for the lane scheduler and converter.
package ps_pkg;
  typedef enum logic [2:0] {
    TRAIN = 3'd0,
    IDLE  = 3'd1,
    HDR   = 3'd2,
    DATA  = 3'd3,
    GAP   = 3'd4
  } state_e;
  localparam logic [3:0] HDR_TAG = 4'hF;
  localparam logic [7:0] COM     = 8'hBC;
endpackage

// File: rtl/ps_lane_scheduler_if.sv
// ps_lane_scheduler_if: requester byte streams in, converter byte/valid out.
interface ps_lane_scheduler_if #(parameter int NUM_REQ = 4) ();
  logic [NUM_REQ-1:0]         req_valid;
  logic [8*NUM_REQ-1:0]       req_data;
  logic [NUM_REQ-1:0]         req_last;
  logic [NUM_REQ-1:0]         req_ready;
  logic [7:0]                 data_out;
  logic                       valid_out;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic                       busy;
  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, data_out, valid_out, grant_id, busy
  );
  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, data_out, valid_out, grant_id, busy
  );
endinterface

// File: rtl/ps_lane_scheduler_rr_pick.sv
// rr_pick: first set request at or above the pointer, wrapping around.
module rr_pick #(parameter int NUM_REQ = 4) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       hit_o
);
  localparam int W = $clog2(NUM_REQ);
  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    idx_o = '0;
    hit_o = |req_i;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % NUM_REQ]) idx_o = W'((int'(ptr_i) + i) % NUM_REQ);
  end
endmodule

// File: rtl/ps_lane_scheduler.sv
// ps_lane_scheduler: round-robin framing of NUM_REQ byte streams onto one serial lane.
module ps_lane_scheduler
  import ps_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int TRAIN_CYC = 16,
  parameter int GAP_CYC   = 2
) (
  input logic clk4_f,
  input logic reset,
  ps_lane_scheduler_if.slave bus
);
  localparam int W  = $clog2(NUM_REQ);
  localparam int TW = $clog2(TRAIN_CYC + 1);
  state_e         state_q, state_d;
  logic [TW-1:0]  train_q, train_d;
  logic [3:0]     gap_q, gap_d;
  logic [7:0]     burst_q, burst_d, burst_inc;
  logic [W-1:0]   ptr_q, ptr_d, gid_q, gid_d, pick_idx;
  logic [7:0]     dout_q, dout_d;
  logic           vout_q, vout_d, pick_hit, accept;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .hit_o (pick_hit)
  );
  assign accept    = (state_q == DATA) && bus.req_valid[gid_q];
  assign burst_inc = burst_q + 8'd1;
  // Outputs lag the state by one edge: HDR loads the header, DATA loads accepted bytes.
  always_comb begin
    state_d = state_q;
    train_d = train_q;
    gap_d   = gap_q;
    burst_d = burst_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    case (state_q)
      TRAIN: begin
        train_d = train_q + TW'(1);
        state_d = (train_q == TW'(TRAIN_CYC - 1)) ? IDLE : TRAIN;
      end
      IDLE: begin
        gid_d   = pick_hit ? pick_idx : gid_q;
        state_d = pick_hit ? HDR : IDLE;
      end
      HDR: begin
        dout_d  = {HDR_TAG, 4'(gid_q)};
        vout_d  = 1'b1;
        burst_d = 8'd0;
        state_d = DATA;
      end
      DATA: begin
        if (accept) begin
          dout_d  = bus.req_data[8*int'(gid_q) +: 8];
          vout_d  = 1'b1;
          burst_d = burst_inc;
          if (bus.req_last[gid_q] || burst_inc == 8'(MAX_BURST)) begin
            ptr_d   = (gid_q == W'(NUM_REQ - 1)) ? '0 : gid_q + W'(1);
            gap_d   = 4'd0;
            state_d = (GAP_CYC == 0) ? IDLE : GAP;
          end
        end
      end
      GAP: begin
        gap_d   = gap_q + 4'd1;
        state_d = (gap_q == 4'(GAP_CYC - 1)) ? IDLE : GAP;
      end
      default: state_d = TRAIN;
    endcase
  end
  always_ff @(posedge clk4_f) begin
    if (reset) begin
      state_q <= TRAIN;
      train_q <= '0;
      gap_q   <= '0;
      burst_q <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      dout_q  <= 8'h00;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      train_q <= train_d;
      gap_q   <= gap_d;
      burst_q <= burst_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
    end
  end
  assign bus.req_ready = (state_q == DATA) ? NUM_REQ'(1) << gid_q : '0;
  assign bus.data_out  = dout_q;
  assign bus.valid_out = vout_q;
  assign bus.grant_id  = gid_q;
  assign bus.busy      = (state_q == HDR) || (state_q == DATA);
endmodule

// File: tb/tb_ps_lane_scheduler.sv
// tb_ps_lane_scheduler: directed cycle-by-cycle checks of framing, round-robin, truncation, bubbles and reset.
module tb_ps_lane_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;
  ps_lane_scheduler_if #(.NUM_REQ(4)) bus ();
  ps_lane_scheduler #(.NUM_REQ(4), .MAX_BURST(8), .TRAIN_CYC(16), .GAP_CYC(2)) dut (
    .clk4_f (clk),
    .reset  (reset),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  task automatic tk();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask
  task automatic put(input int i, input logic [7:0] d, input logic l);
    bus.req_data[8*i +: 8] = d;
    bus.req_last[i] = l;
  endtask
  task automatic idle_chk(input string tag);
    chk(tag, {bus.busy, bus.valid_out}, 2'b00);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    tk();
    tk();
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_grant", bus.grant_id, 2'd0);
    chk("rst_ready", bus.req_ready, 4'h0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tk();
      chk("train_idle_valid", bus.valid_out, 1'b0);
      chk("train_idle_ready", bus.req_ready, 4'h0);
      chk("train_idle_busy", bus.busy, 1'b0);
    end
    // all four requesters, one-byte packets, served 0,1,2,3,0
    for (int i = 0; i < 4; i++) put(i, 8'hA0 + 8'(i), 1'b1);
    bus.req_valid = 4'hF;
    for (int b = 0; b < 5; b++) begin
      tk();
      chk("rr_grant", bus.grant_id, 32'(b % 4));
      chk("rr_busy", {bus.busy, bus.valid_out}, 2'b10);
      tk();
      chk("rr_hdr", {bus.valid_out, bus.data_out}, {1'b1, 8'hF0 + 8'(b % 4)});
      chk("rr_ready", bus.req_ready, 4'(1) << (b % 4));
      tk();
      chk("rr_byte", {bus.valid_out, bus.data_out}, {1'b1, 8'hA0 + 8'(b % 4)});
      tk();
      idle_chk("rr_gap1");
      tk();
      idle_chk("rr_gap2");
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    // requester 2: FF AA 25
    put(2, 8'hFF, 1'b0);
    bus.req_valid = 4'b0100;
    tk(); chk("r2_grant", bus.grant_id, 2'd2);
    tk(); chk("r2_hdr", {bus.valid_out, bus.data_out}, 9'h1F2);
    tk(); chk("r2_b0", {bus.valid_out, bus.data_out}, 9'h1FF); put(2, 8'hAA, 1'b0);
    tk(); chk("r2_b1", {bus.valid_out, bus.data_out}, 9'h1AA); put(2, 8'h25, 1'b1);
    tk(); chk("r2_b2", {bus.valid_out, bus.data_out}, 9'h125);
    chk("r2_done_busy", bus.busy, 1'b0);
    put(0, 8'h30, 1'b1);
    put(3, 8'h33, 1'b1);
    bus.req_valid = 4'b1001;
    tk(); idle_chk("r2_gap1");
    tk(); idle_chk("r2_gap2");
    tk(); chk("ptr3_grant", bus.grant_id, 2'd3); chk("ptr3_valid", bus.valid_out, 1'b0);
    tk(); chk("ptr3_hdr", {bus.valid_out, bus.data_out}, 9'h1F3);
    tk(); chk("ptr3_byte", {bus.valid_out, bus.data_out}, 9'h133);
    bus.req_valid = 4'b0001;
    tk(); tk();
    tk(); chk("wrap_grant", bus.grant_id, 2'd0);
    tk(); chk("wrap_hdr", {bus.valid_out, bus.data_out}, 9'h1F0);
    tk(); chk("wrap_byte", {bus.valid_out, bus.data_out}, 9'h130);
    bus.req_valid = '0;
    bus.req_last  = '0;
    tk(); tk();
    // requester 1: 10 bytes without last, truncated at 8
    put(1, 8'h01, 1'b0);
    bus.req_valid = 4'b0010;
    tk(); chk("trunc_grant", bus.grant_id, 2'd1);
    tk(); chk("trunc_hdr", {bus.valid_out, bus.data_out}, 9'h1F1);
    for (int j = 1; j <= 8; j++) begin
      tk();
      chk("trunc_byte", {bus.valid_out, bus.data_out}, {1'b1, 8'(j)});
      put(1, 8'(j + 1), 1'b0);
    end
    chk("trunc_busy", bus.busy, 1'b0);
    tk(); idle_chk("trunc_gap1"); chk("trunc_gap_ready", bus.req_ready, 4'h0);
    tk(); idle_chk("trunc_gap2");
    tk(); chk("trunc_regrant", bus.grant_id, 2'd1);
    tk(); chk("trunc_hdr2", {bus.valid_out, bus.data_out}, 9'h1F1);
    tk(); chk("trunc_b9", {bus.valid_out, bus.data_out}, 9'h109); put(1, 8'h0A, 1'b1);
    tk(); chk("trunc_b10", {bus.valid_out, bus.data_out}, 9'h10A);
    chk("trunc_end_busy", bus.busy, 1'b0);
    bus.req_valid = '0;
    bus.req_last  = '0;
    tk(); tk();
    // requester 0 with a 3-cycle bubble
    put(0, 8'h51, 1'b0);
    bus.req_valid = 4'b0001;
    tk(); chk("bub_grant", bus.grant_id, 2'd0);
    tk(); chk("bub_hdr", {bus.valid_out, bus.data_out}, 9'h1F0);
    tk(); chk("bub_b0", {bus.valid_out, bus.data_out}, 9'h151); put(0, 8'h52, 1'b0);
    tk(); chk("bub_b1", {bus.valid_out, bus.data_out}, 9'h152);
    bus.req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tk();
      chk("bub_hole", {bus.busy, bus.valid_out}, 2'b10);
      chk("bub_ready", bus.req_ready, 4'b0001);
    end
    put(0, 8'h53, 1'b0);
    bus.req_valid = 4'b0001;
    tk(); chk("bub_b2", {bus.valid_out, bus.data_out}, 9'h153); put(0, 8'h54, 1'b1);
    tk(); chk("bub_b3", {bus.valid_out, bus.data_out}, 9'h154);
    bus.req_valid = '0;
    bus.req_last  = '0;
    tk(); tk();
    // reset during requester 3's DATA phase
    put(3, 8'h77, 1'b0);
    bus.req_valid = 4'b1000;
    tk(); chk("mid_grant", bus.grant_id, 2'd3);
    tk(); chk("mid_hdr", {bus.valid_out, bus.data_out}, 9'h1F3);
    tk(); chk("mid_byte", {bus.valid_out, bus.data_out}, 9'h177);
    reset = 1'b1;
    tk();
    chk("mid_rst_out", {bus.busy, bus.valid_out, bus.data_out, bus.grant_id, bus.req_ready}, 16'h0000);
    reset = 1'b0;
    put(0, 8'h60, 1'b1);
    bus.req_valid = 4'b1001;
    for (int c = 0; c < 16; c++) begin
      tk();
      idle_chk("retrain");
    end
    tk(); chk("retrain_grant", {bus.busy, bus.grant_id}, 3'b100);
    tk(); chk("retrain_hdr", {bus.valid_out, bus.data_out}, 9'h1F0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ps_lane_scheduler.md
# ps_lane_scheduler

Round-robin scheduler that shares one parallel-to-serial lane among NUM_REQ byte-stream requesters. It sits directly upstream of the paralelo-serial converter in the clk4_f domain and drives that converter's 8-bit data and valid inputs. It sequences the lane through a post-reset training period, then runs framed bursts: a header byte followed by payload. Idle cycles (valid low) make the converter emit its comma/idle symbol.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 8, maximum payload bytes per grant (1..255)
- TRAIN_CYC, 16, cycles of forced idle after reset
- GAP_CYC, 2, idle cycles between bursts (0..15)

Ports:
- clk4_f  in  1  byte clock; the only clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte on its slice of req_data
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
- req_last  in  NUM_REQ  byte on requester i is the last of its packet
- req_ready  out  NUM_REQ  one-hot; byte of requester i accepted on an edge where valid and ready are both high
- data_out  out  8  byte to the converter's data_in
- valid_out  out  1  to the converter's valid_in
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester
- busy  out  1  high in HDR and DATA

## Operation
- State machine: TRAIN, IDLE, HDR, DATA, GAP. State, data_out, valid_out, grant_id and the round-robin pointer are all registered. req_ready is decoded from state only: req_ready[grant_id] = 1 only in DATA.
- Reset values: state TRAIN, train/gap/burst counters 0, pointer 0, grant_id 0, data_out 8'h00, valid_out 0, req_ready 0, busy 0.
- TRAIN: valid_out=0 for TRAIN_CYC cycles, then IDLE. Requests are ignored during TRAIN.
- IDLE: if req_valid is non-zero, grant the first set bit searching upward from the pointer with wrap-around. Latch grant_id and go to HDR. Otherwise stay in IDLE with valid_out=0.
- HDR (one cycle): data_out = 8'hF0 | grant_id, valid_out=1, burst counter cleared.
- DATA:
  - On an accept: next data_out = req_data slice of grant_id, valid_out=1, burst counter +1.
  - If req_valid[grant_id] is low, the cycle is a bubble: valid_out=0, stay in DATA.
  - Exit to GAP after accepting a byte with req_last set, or after the MAX_BURST-th accepted byte.
  - A packet truncated by MAX_BURST continues in a later grant with a new header.
- GAP: valid_out=0 for GAP_CYC cycles, then IDLE. If GAP_CYC=0, go directly to IDLE. On leaving DATA, pointer = grant_id+1 modulo NUM_REQ.
- Width rule: the burst counter is 8 bits and compares equal to MAX_BURST; it never wraps.
- Reset has priority in every state. Asserting it mid-burst drops the burst with no trailing byte and restarts TRAIN.

## Timing
- Grant decision in IDLE at edge E puts the header on data_out at E+1.
- The first possible accept is at edge E+2. That byte appears on data_out during the cycle after E+2 (one-cycle latency from accept to output).
- Minimum slot per burst of n bytes with no bubbles: 1 (IDLE) + 1 (HDR) + n + GAP_CYC cycles.
- A request rising in GAP or HDR waits for the next IDLE decision. A request that drops before it is granted is never served.
- When multiple requests are simultaneous, round-robin gives each requester at most one burst before any other active requester is served again.

## Structure
- Shared package ps_pkg holds:
  - state encoding constants: TRAIN=0, IDLE=1, HDR=2, DATA=3, GAP=4
  - HDR_TAG = 4'hF
  - COM symbol 8'hBC, used by the converter
- Sub-module rr_pick: combinational round-robin first-set search over req_valid from the pointer, returning an index and a hit flag. Parameterized by NUM_REQ.

## Test plan
- Reset, then no requests -> valid_out=0 for 16 cycles, then IDLE with valid_out held at 0 and req_ready=0.
- Requester 2 sends 8'hFF, 8'hAA, 8'h25 with last on 8'h25 -> data_out sequence F2, FF, AA, 25 with valid_out=1, then 2 idle cycles, pointer=3.
- All four requesters valid with 1-byte packets -> headers F0, F1, F2, F3 in that order, each followed by its byte, then F0 again.
- Requester 1 streams 10 bytes with no last, MAX_BURST=8 -> F1 plus 8 bytes, gap, then after requester 1 is regranted, F1 plus the remaining 2 bytes.
- Bubble: requester 0 drops valid for 3 cycles mid-packet -> valid_out=0 for exactly those 3 cycles, no byte lost or duplicated, header not repeated.
- Reset asserted during the DATA phase of requester 3 -> next cycle all outputs at reset values, TRAIN restarts for 16 cycles, pointer=0.
